// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arb_pkg
// Brief   : Shared types and default sizes for the data-memory arbiter.
// Revision: 1.0
// ============================================================================
package dmem_arb_pkg;

    localparam int c_DEF_ADDR_W       = 32;
    localparam int c_DEF_DATA_W       = 32;
    localparam int c_DEF_STARVE_LIMIT = 4;
    localparam int c_STARVE_CW        = 4;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_CPU  = 2'b01,
        GNT_HOST = 2'b10
    } gnt_e;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter_if
// Brief   : CPU, host and dmem bus signals of the data-memory arbiter.
// Revision: 1.0
// ============================================================================
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic [DATA_W-1:0] host_rdata;
    logic              host_ack;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [1:0]        grant;
    logic [31:0]       stall_count;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  host_req, host_we, host_addr, host_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_stall, host_rdata, host_ack,
        output mem_we, mem_addr, mem_wdata, grant, stall_count
    );

    // Requesters and memory side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output host_req, host_we, host_addr, host_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_stall, host_rdata, host_ack,
        input  mem_we, mem_addr, mem_wdata, grant, stall_count
    );

endinterface : dmem_arbiter_if
`default_nettype wire

// File: rtl/arb_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module  : arb_starve_ctr
// Brief   : Saturating count of cycles a host request lost; raises force at limit.
// Revision: 1.0
// ============================================================================
module arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = c_DEF_STARVE_LIMIT
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_host_req,
    input  wire logic i_host_gnt,
    output logic      o_force
);

    localparam logic [c_STARVE_CW-1:0] c_LIMIT = c_STARVE_CW'(STARVE_LIMIT);

    logic [c_STARVE_CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!i_host_req || i_host_gnt) begin
            r_cnt <= '0;
        end else if (r_cnt != c_LIMIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_force = i_host_req & (r_cnt == c_LIMIT);

endmodule : arb_starve_ctr
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter
// Brief   : CPU-priority arbiter for the dmem port with starvation-forced host
//           grants. Optional macro ARB_STATS_EN enables the CPU stall counter.
// Revision: 1.0
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = c_DEF_ADDR_W,
    parameter int DATA_W       = c_DEF_DATA_W,
    parameter int STARVE_LIMIT = c_DEF_STARVE_LIMIT
) (
    input  wire logic     clk,
    input  wire logic     reset,
    dmem_arbiter_if.slave bus
);

    logic              w_force;
    gnt_e              w_gnt;
    logic [DATA_W-1:0] r_host_rdata;
    logic              r_host_ack;
    gnt_e              r_grant;

    arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .reset      (reset),
        .i_host_req (bus.host_req),
        .i_host_gnt (w_gnt == GNT_HOST),
        .o_force    (w_force)
    );

    // Nobody is granted during reset, which also keeps dmem writes off.
    always_comb begin
        w_gnt = GNT_NONE;
        if (!reset) begin
            if (w_force)           w_gnt = GNT_HOST;
            else if (bus.cpu_req)  w_gnt = GNT_CPU;
            else if (bus.host_req) w_gnt = GNT_HOST;
        end
    end

    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        case (w_gnt)
            GNT_CPU: begin
                bus.mem_we = bus.cpu_we;
            end
            GNT_HOST: begin
                bus.mem_we    = bus.host_we;
                bus.mem_addr  = bus.host_addr;
                bus.mem_wdata = bus.host_wdata;
            end
            default: ;
        endcase
    end

    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.cpu_stall = bus.cpu_req & (w_gnt != GNT_CPU) & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_host_ack   <= 1'b0;
            r_host_rdata <= '0;
            r_grant      <= GNT_NONE;
        end else begin
            r_grant    <= w_gnt;
            r_host_ack <= (w_gnt == GNT_HOST);
            if ((w_gnt == GNT_HOST) && !bus.host_we) begin
                r_host_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.host_ack   = r_host_ack;
    assign bus.host_rdata = r_host_rdata;
    assign bus.grant      = r_grant;

`ifdef ARB_STATS_EN
    logic [31:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (bus.cpu_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign bus.stall_count = r_stall_count;
`else
    assign bus.stall_count = 32'd0;
`endif

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_arbiter
// Brief   : Directed vector table plus starvation / reset sequences for dmem_arbiter.
// Revision: 1.0
// ============================================================================
module tb_dmem_arbiter;

    logic clk;
    logic reset;
    logic mem_init;
    int   n_vec;
    int   n_err;

    logic [31:0] mem [0:255];

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-addressed dmem model: combinational read, synchronous write
    assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        end
    end

    typedef struct {
        logic        cpu_req;
        logic        cpu_we;
        logic [31:0] cpu_addr;
        logic [31:0] cpu_wdata;
        logic        host_req;
        logic        host_we;
        logic [31:0] host_addr;
        logic [31:0] host_wdata;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_stall;
        logic [1:0]  e_grant;
        logic        e_ack;
        logic        chk_hrd;
        logic [31:0] e_hrd;
        logic        chk_crd;
        logic [31:0] e_crd;
    } vec_t;

    vec_t vecs [0:7];

`ifdef ARB_STATS_EN
    localparam logic [31:0] c_EXP_STALLS = 32'd3;
`else
    localparam logic [31:0] c_EXP_STALLS = 32'd0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.cpu_req    = 1'b0;
        bus.cpu_we     = 1'b0;
        bus.cpu_addr   = 32'd0;
        bus.cpu_wdata  = 32'd0;
        bus.host_req   = 1'b0;
        bus.host_we    = 1'b0;
        bus.host_addr  = 32'd0;
        bus.host_wdata = 32'd0;
    endtask

    // CPU hammers a read of 0x300 while the host reads address 100 (holds 5);
    // the host must be forced on the 5th cycle and acked on the 6th.
    task automatic run_starve();
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus.cpu_req   = 1'b1;
            bus.cpu_we    = 1'b0;
            bus.cpu_addr  = 32'h300;
            bus.host_req  = 1'b1;
            bus.host_we   = 1'b0;
            bus.host_addr = 32'd100;
            #1;
            chk($sformatf("starve_stall_c%0d", c), 32'(bus.cpu_stall), 32'(c == 5));
            chk($sformatf("starve_addr_c%0d", c), bus.mem_addr, (c == 5) ? 32'd100 : 32'h300);
            @(posedge clk); #1;
            chk($sformatf("starve_ack_c%0d", c), 32'(bus.host_ack), 32'(c == 5));
        end
        @(negedge clk);
        bus.host_req = 1'b0;
        #1;
        chk("starve_ackcyc_stall", 32'(bus.cpu_stall), 32'd0);
        chk("starve_ackcyc_ack", 32'(bus.host_ack), 32'd1);
        chk("starve_rdata", bus.host_rdata, 32'd5);
        @(posedge clk); #1;
        chk("starve_ack_drop", 32'(bus.host_ack), 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        //        creq cwe caddr    cwdata  hreq hwe haddr  hwdata        we addr     wdata         stl grant  ack chr hrd           ccr crd
        vecs[0] = '{1, 1, 32'd100, 32'd5,  0, 0, 32'd0,   32'd0,        1, 32'd100, 32'd5,        0, 2'b01, 0, 0, 32'd0,        0, 32'd0};
        vecs[1] = '{0, 1, 32'h40,  32'h77, 0, 0, 32'd0,   32'd0,        0, 32'h40,  32'h77,       0, 2'b00, 0, 0, 32'd0,        0, 32'd0};
        vecs[2] = '{0, 0, 32'd0,   32'd0,  1, 1, 32'd200, 32'hDEADBEEF, 1, 32'd200, 32'hDEADBEEF, 0, 2'b10, 1, 0, 32'd0,        0, 32'd0};
        vecs[3] = '{0, 0, 32'd0,   32'd0,  1, 0, 32'd200, 32'd0,        0, 32'd200, 32'd0,        0, 2'b10, 1, 1, 32'hDEADBEEF, 0, 32'd0};
        vecs[4] = '{1, 0, 32'd100, 32'd0,  0, 0, 32'd0,   32'd0,        0, 32'd100, 32'd0,        0, 2'b01, 0, 1, 32'hDEADBEEF, 1, 32'd5};
        vecs[5] = '{1, 1, 32'd104, 32'd1,  1, 1, 32'd104, 32'd2,        1, 32'd104, 32'd1,        0, 2'b01, 0, 0, 32'd0,        0, 32'd0};
        vecs[6] = '{0, 0, 32'd0,   32'd0,  1, 1, 32'd104, 32'd2,        1, 32'd104, 32'd2,        0, 2'b10, 1, 0, 32'd0,        0, 32'd0};
        vecs[7] = '{0, 0, 32'd104, 32'd0,  0, 0, 32'd0,   32'd0,        0, 32'd104, 32'd0,        0, 2'b00, 0, 0, 32'd0,        1, 32'd2};

        // Reset with both requesters active: nothing may reach dmem
        mem_init = 1'b1;
        reset    = 1'b1;
        drive_idle();
        bus.cpu_req    = 1'b1;
        bus.cpu_we     = 1'b1;
        bus.host_req   = 1'b1;
        bus.host_we    = 1'b1;
        #20;
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_cpu_stall", 32'(bus.cpu_stall), 32'd0);
        chk("rst_host_ack", 32'(bus.host_ack), 32'd0);
        chk("rst_host_rdata", bus.host_rdata, 32'd0);
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_stall_count", bus.stall_count, 32'd0);
        #2;
        reset    = 1'b0;
        mem_init = 1'b0;
        drive_idle();

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.cpu_req    = vecs[i].cpu_req;
            bus.cpu_we     = vecs[i].cpu_we;
            bus.cpu_addr   = vecs[i].cpu_addr;
            bus.cpu_wdata  = vecs[i].cpu_wdata;
            bus.host_req   = vecs[i].host_req;
            bus.host_we    = vecs[i].host_we;
            bus.host_addr  = vecs[i].host_addr;
            bus.host_wdata = vecs[i].host_wdata;
            #1;
            chk($sformatf("v%0d_mem_we", i), 32'(bus.mem_we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d_mem_addr", i), bus.mem_addr, vecs[i].e_addr);
            if (vecs[i].e_we) chk($sformatf("v%0d_mem_wdata", i), bus.mem_wdata, vecs[i].e_wdata);
            chk($sformatf("v%0d_cpu_stall", i), 32'(bus.cpu_stall), 32'(vecs[i].e_stall));
            if (vecs[i].chk_crd) chk($sformatf("v%0d_cpu_rdata", i), bus.cpu_rdata, vecs[i].e_crd);
            @(posedge clk); #1;
            chk($sformatf("v%0d_grant", i), 32'(bus.grant), 32'(vecs[i].e_grant));
            chk($sformatf("v%0d_host_ack", i), 32'(bus.host_ack), 32'(vecs[i].e_ack));
            if (vecs[i].chk_hrd) chk($sformatf("v%0d_host_rdata", i), bus.host_rdata, vecs[i].e_hrd);
        end
        chk("mem104_final", mem[26], 32'd2);
        chk("mem200_final", mem[50], 32'hDEADBEEF);

        drive_idle();
        run_starve();

        // Reset lands on a cycle where the host alone would be granted a write
        @(negedge clk);
        drive_idle();
        bus.host_req   = 1'b1;
        bus.host_we    = 1'b1;
        bus.host_addr  = 32'd300;
        bus.host_wdata = 32'hAA;
        reset          = 1'b1;
        #1;
        chk("midrst_mem_we", 32'(bus.mem_we), 32'd0);
        @(posedge clk); #1;
        chk("midrst_ack", 32'(bus.host_ack), 32'd0);
        chk("midrst_grant", 32'(bus.grant), 32'd0);
        chk("midrst_rdata", bus.host_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        #1;
        chk("midrst_mem300", mem[75], 32'd0);
        @(posedge clk); #1;
        chk("midrst_ack_after", 32'(bus.host_ack), 32'd0);

        for (int r = 0; r < 3; r++) run_starve();
        chk("stall_count", bus.stall_count, c_EXP_STALLS);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port of the MIPS computer between two requesters: the CPU data port and a host port used for test loading and debug readback.
- The CPU has priority so the single-cycle datapath normally sees zero wait states.
- The host is guaranteed service by a starvation counter.
- The block sits between the CPU, the host and dmem. dmem reads combinationally and writes synchronously.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data word width.
- STARVE_LIMIT, 4, consecutive cycles a pending host request may lose before it is forced a grant (range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- cpu_req  in  1  CPU requests a memory access this cycle.
- cpu_we  in  1  CPU write enable.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  read data to CPU (combinational).
- cpu_stall  out  1  CPU must hold its state and retry next cycle.
- host_req  in  1  host request; held with its addr/we/wdata until host_ack.
- host_we  in  1  host write enable.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_rdata  out  DATA_W  registered read data, valid while host_ack=1.
- host_ack  out  1  one-cycle pulse, registered, marks completion.
- mem_we  out  1  to dmem.
- mem_addr  out  ADDR_W  to dmem.
- mem_wdata  out  DATA_W  to dmem.
- mem_rdata  in  DATA_W  from dmem, combinational read.
- grant  out  2  registered last grant: 00 none, 01 CPU, 10 host.
- stall_count  out  32  CPU stall cycles (see Optional Feature).

Behaviour:
- Reset values: host_ack=0, host_rdata=0, grant=00, starvation counter=0, stall_count=0. During any reset cycle, mem_we=0 and cpu_stall=0.
- Grant selection is combinational each cycle from the requests and the registered counter:
  - force_host = host_req & (starve_cnt == STARVE_LIMIT).
  - If force_host, grant host. Else if cpu_req, grant CPU. Else if host_req, grant host. Else no grant.
- A pending host request is host_req=1 with no host_ack issued this cycle. host_req asserted in the same cycle as host_ack counts as a new request.
- Output mux:
  - mem_addr, mem_we and mem_wdata come from the granted requester.
  - With no grant: mem_we=0, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
  - cpu_rdata = mem_rdata at all times.
- cpu_stall = cpu_req & (grant is not CPU). The CPU write is not performed in a stalled cycle.
- Host transaction (completes in one granted cycle):
  - In the granted cycle, a write happens at the clock edge. A read samples mem_rdata into host_rdata at the edge.
  - host_ack=1 in the following cycle for exactly one cycle. host_rdata holds until the next host grant.
  - At most one host grant per ack: while host_ack=1, the held request is treated as new. The host must drop host_req in the ack cycle or present the next transaction.
- Starvation counter:
  - Increments when a host request is pending and not granted.
  - Clears on a host grant or when host_req=0.
  - Saturates at STARVE_LIMIT.
- Latency:
  - CPU: 0 added cycles when no forced host grant occurs.
  - Host: ack at most STARVE_LIMIT+2 cycles after host_req rises.
- Boundary: both requesters targeting the same address cannot conflict, because only one is granted per cycle.
- Reset mid-operation: an in-flight host transaction is dropped, no ack is issued, and the host must re-request.
- The grant register updates every cycle to the current grant.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined: stall_count increments each cycle with cpu_stall=1. It saturates at 0xFFFFFFFF and clears on reset.
- Undefined: stall_count is tied to 0 and no counter logic is synthesized.

Decomposition:
- Package dmem_arb_pkg holds:
  - grant encoding typedef (GNT_NONE, GNT_CPU, GNT_HOST);
  - default widths;
  - STARVE_LIMIT default.
- One sub-module, arb_starve_ctr: the saturating starvation counter with force output.
- Mux and handshake logic stay in the top module.

Test Plan:
- Reset held 22 ns, then CPU writes 0x00000005 to address 100 with no host activity -> mem_we=1, mem_addr=100, cpu_stall=0, grant=01.
- Host-only write of 0xDEADBEEF to address 200, then a read of address 200 -> each completes with host_ack one cycle after its grant; read gives host_rdata=0xDEADBEEF; grant=10.
- CPU requests continuously, host_req held on a read of address 100 -> host is forced on cycle STARVE_LIMIT+1 (5th); cpu_stall=1 for exactly that cycle; host_ack next cycle.
- Simultaneous CPU write (address 104 = 0x1) and host write (address 104 = 0x2), no starvation -> CPU wins; the host is granted the next cycle CPU idles; final memory value is 0x2.
- Reset asserted while host_req is pending in a granted cycle -> mem_we=0, host_ack never pulses; all outputs at reset values on the next edge.
- With ARB_STATS_EN defined, run the starvation scenario 3 times -> stall_count=3. Undefined -> stall_count=0.
